// File: rtl/store_narrow_unit.sv
// Store-path narrowing unit: writes the 1/2/4 low bytes of a register one byte per ack.
// Optional STORE_ALIGN_CHECK_EN rejects misaligned halfword/word stores.
module store_narrow_unit #(
    parameter int ADDR_W     = 32,
    parameter bit LITTLE_END = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, WRITE, DONE, ERR} state_t;

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [1:0]        last_q, last_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       data_q, data_d;
    logic [1:0]        req_last;
    logic              illegal;

    logic              we_d, ready_d, done_d, err_d;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        wdata_d;
    logic [1:0]        sel;

    always_comb begin
        req_last = 2'd3;
        unique case (req_size)
            2'b00:   req_last = 2'd0;
            2'b01:   req_last = 2'd1;
            default: req_last = 2'd3;
        endcase
    end

    always_comb begin
        illegal = (req_size == 2'b11);
`ifdef STORE_ALIGN_CHECK_EN
        if (req_size == 2'b01 && req_addr[0])
            illegal = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
            illegal = 1'b1;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            last_q  <= 2'd0;
            base_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            base_q  <= base_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        base_d  = base_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    base_d  = req_addr;
                    data_d  = req_data;
                    last_d  = req_last;
                    idx_d   = 2'd0;
                    state_d = illegal ? ERR : WRITE;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    if (idx_q == last_q) begin
                        state_d = DONE;
                        idx_d   = 2'd0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            DONE, ERR: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they can be registered
    always_comb begin
        ready_d = (state_d == IDLE);
        we_d    = (state_d == WRITE);
        done_d  = (state_d == DONE);
        err_d   = (state_d == ERR);
        sel     = LITTLE_END ? idx_d : (last_d - idx_d);
        addr_d  = '0;
        wdata_d = 8'h00;
        if (we_d) begin
            addr_d = base_d + ADDR_W'(idx_d);
            unique case (sel)
                2'd0: wdata_d = data_d[7:0];
                2'd1: wdata_d = data_d[15:8];
                2'd2: wdata_d = data_d[23:16];
                2'd3: wdata_d = data_d[31:24];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            req_ready <= ready_d;
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Bench for store_narrow_unit: little- and big-endian instances share one stimulus stream.
module tb_store_narrow_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_size = '0;
    logic        mem_ack = 1'b0;

    logic        ready_le, we_le, done_le, err_le;
    logic [31:0] addr_le;
    logic [7:0]  wdata_le;
    logic        ready_be, we_be, done_be, err_be;
    logic [31:0] addr_be;
    logic [7:0]  wdata_be;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    store_narrow_unit #(.ADDR_W(32), .LITTLE_END(1'b1)) u_le (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_le),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_we(we_le), .mem_addr(addr_le), .mem_wdata(wdata_le),
        .mem_ack(mem_ack), .done(done_le), .err(err_le)
    );

    store_narrow_unit #(.ADDR_W(32), .LITTLE_END(1'b0)) u_be (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_be),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_we(we_be), .mem_addr(addr_be), .mem_wdata(wdata_be),
        .mem_ack(mem_ack), .done(done_be), .err(err_be)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        int          stall;
        int          n;
        logic [7:0]  le [4];
        logic [7:0]  be [4];
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t model(input logic [31:0] addr, input logic [31:0] data,
                                   input logic [1:0] size, input int stall);
        vec_t v;
        int n;
        v.addr = addr; v.data = data; v.size = size; v.stall = stall;
        n = (size == 0) ? 1 : (size == 1) ? 2 : (size == 2) ? 4 : 0;
`ifdef STORE_ALIGN_CHECK_EN
        if (n == 2 && addr % 2 != 0) n = 0;
        if (n == 4 && addr % 4 != 0) n = 0;
`endif
        v.n = n;
        for (int k = 0; k < 4; k++) begin
            v.le[k] = (k < n) ? 8'((data >> (8 * k)) & 32'hFF) : 8'h00;
            v.be[k] = (k < n) ? 8'((data >> (8 * (n - 1 - k))) & 32'hFF) : 8'h00;
        end
        return v;
    endfunction

    task automatic garbage();
        req_valid = 1'($urandom);
        req_addr  = $urandom;
        req_data  = $urandom;
        req_size  = 2'($urandom);
    endtask

    // Entered and left at a negedge with the unit idle
    task automatic run_vec(input vec_t v);
        int st;
        chk("ready_le_idle", 32'(ready_le), 1);
        chk("ready_be_idle", 32'(ready_be), 1);
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_data  = v.data;
        req_size  = v.size;
        mem_ack   = 1'($urandom);
        @(negedge clk);
        garbage();
        if (v.n == 0) begin
            chk("err_le", 32'(err_le), 1);
            chk("err_be", 32'(err_be), 1);
            chk("we_err", 32'(we_le | we_be), 0);
            chk("ready_err", 32'(ready_le | ready_be), 0);
            @(negedge clk);
            req_valid = 1'b0;
            chk("err_pulse", 32'(err_le | err_be), 0);
            chk("ready_after_err", 32'(ready_le & ready_be), 1);
            chk("we_after_err", 32'(we_le | we_be), 0);
            return;
        end
        for (int i = 0; i < v.n; i++) begin
            st = (v.stall >= 0) ? v.stall : int'($urandom_range(0, 2));
            for (int s = 0; s <= st; s++) begin
                chk("we_le", 32'(we_le), 1);
                chk("we_be", 32'(we_be), 1);
                chk("addr_le", addr_le, v.addr + 32'(i));
                chk("addr_be", addr_be, v.addr + 32'(i));
                chk("wdata_le", 32'(wdata_le), 32'(v.le[i]));
                chk("wdata_be", 32'(wdata_be), 32'(v.be[i]));
                chk("busy_flags", 32'({ready_le, ready_be, done_le, done_be, err_le, err_be}), 0);
                mem_ack = (s == st);
                garbage();
                @(negedge clk);
            end
        end
        chk("done_le", 32'(done_le), 1);
        chk("done_be", 32'(done_be), 1);
        chk("we_done", 32'(we_le | we_be), 0);
        chk("ready_done", 32'(ready_le | ready_be), 0);
        mem_ack = 1'($urandom);
        garbage();
        @(negedge clk);
        req_valid = 1'b0;
        chk("done_pulse", 32'(done_le | done_be), 0);
        chk("ready_after_done", 32'(ready_le & ready_be), 1);
    endtask

    vec_t tbl [7];
    vec_t rv;

    initial begin
        tbl[0] = model(32'h0000_0100, 32'hA1B2_C3D4, 2'b10, 0);
        tbl[1] = model(32'h0000_0020, 32'hFFFF_1234, 2'b01, 0);
        tbl[2] = model(32'h0000_0040, 32'h1234_567E, 2'b00, 3);
        tbl[3] = model(32'h0000_0080, 32'hDEAD_BEEF, 2'b11, 0);
        tbl[4] = model(32'h0000_0102, 32'h5566_7788, 2'b10, 0);
        tbl[5] = model(32'hFFFF_FFFE, 32'hCAFE_BABE, 2'b10, 1);
        tbl[6] = model(32'h0000_0033, 32'h0000_9A5B, 2'b01, -1);
        // Hand-checked expectations for the first entries
        chk("tbl_word_le0", 32'(tbl[0].le[0]), 32'hD4);
        chk("tbl_half_be0", 32'(tbl[1].be[0]), 32'h12);

        #12;
        chk("rst_ready", 32'(ready_le & ready_be), 1);
        chk("rst_we", 32'(we_le | we_be), 0);
        chk("rst_addr", addr_le | addr_be, 0);
        chk("rst_wdata", 32'(wdata_le | wdata_be), 0);
        chk("rst_done_err", 32'(done_le | done_be | err_le | err_be), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 7; t++)
            run_vec(tbl[t]);

        // Reset during the second byte of a word store
        req_valid = 1'b1; req_addr = 32'h200; req_data = 32'h0BAD_F00D; req_size = 2'b10;
        mem_ack = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_addr", addr_le, 32'h201);
        chk("rst_mid_we", 32'(we_le), 1);
        rst_n = 1'b0;
        #1;
        chk("async_we", 32'(we_le | we_be), 0);
        chk("async_ready", 32'(ready_le & ready_be), 1);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("no_done_le", 32'(done_le | done_be), 0);
        chk("ready_post_rst", 32'(ready_le & ready_be), 1);
        run_vec(tbl[0]);

        for (int r = 0; r < 60; r++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3))) : $urandom;
            rv = model(a, $urandom, 2'($urandom_range(0, 3)), -1);
            run_vec(rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
